// File: rtl/writeback_arbiter.sv
// Register-file write-port producer: merges buffered ALU results and unbuffered,
// priority load results into one writeback packet per cycle.

package writeback_arbiter_pkg;

   typedef struct packed {
      logic        wb_en;
      logic [4:0]  wb_sel;
      logic [31:0] wb_data;
   } rv32_writeback_packet_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } alu_entry_t;

endpackage

module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            alu_valid,
   output logic                            alu_ready,
   input  logic [4:0]                      alu_rd,
   input  logic [31:0]                     alu_data,
   input  logic                            mem_valid,
   output logic                            mem_ready,
   input  logic [4:0]                      mem_rd,
   input  logic [31:0]                     mem_data,
   output rv32_writeback_packet_t          writeback_packet,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   alu_entry_t             fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          count_q;
   logic [SW-1:0]          starve_q;
   rv32_writeback_packet_t wb_q;

   logic       fifo_req;
   logic       force_fifo;
   logic       grant_mem;
   logic       grant_fifo;
   logic       push;
   logic       pop;
   alu_entry_t head;

   // Arbitration: memory has priority unless the FIFO has waited STARVE_LIMIT grants.
   assign fifo_req   = (count_q != '0);
   assign force_fifo = fifo_req && (starve_q == SW'(STARVE_LIMIT));
   assign grant_mem  = mem_valid && !force_fifo;
   assign grant_fifo = fifo_req && !grant_mem;

   assign alu_ready  = (count_q < CW'(FIFO_DEPTH));
   assign mem_ready  = grant_mem;
   assign push       = alu_valid && alu_ready;
   assign pop        = grant_fifo;
   assign head       = fifo_mem[rd_ptr];

   assign writeback_packet = wb_q;
   assign fifo_count       = count_q;

   // Payload storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{rd: alu_rd, data: alu_data};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         starve_q <= '0;
         wb_q     <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);

         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase

         if (grant_fifo || !fifo_req) begin
            starve_q <= '0;
         end else if (grant_mem && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_q <= starve_q + SW'(1);
         end

         // x0 results are consumed but never signalled as a write.
         if (grant_mem) begin
            wb_q.wb_en   <= (mem_rd != 5'd0);
            wb_q.wb_sel  <= mem_rd;
            wb_q.wb_data <= mem_data;
         end else if (grant_fifo) begin
            wb_q.wb_en   <= (head.rd != 5'd0);
            wb_q.wb_sel  <= head.rd;
            wb_q.wb_data <= head.data;
         end else begin
            wb_q.wb_en   <= 1'b0;
         end
      end
   end

   a_alu_stable: assert property (@(posedge clk) disable iff (!resetn)
      (alu_valid && !alu_ready) |=> (!alu_valid || ($stable(alu_rd) && $stable(alu_data))));

   a_mem_stable: assert property (@(posedge clk) disable iff (!resetn)
      (mem_valid && !mem_ready) |=> (!mem_valid || ($stable(mem_rd) && $stable(mem_data))));

   a_no_push_full: assert property (@(posedge clk) disable iff (!resetn)
      !(push && (count_q == CW'(FIFO_DEPTH))));

   a_no_pop_empty: assert property (@(posedge clk) disable iff (!resetn)
      !(pop && (count_q == '0)));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: latency, x0 suppression, starvation guard,
// ordering, pointer wrap and asynchronous reset.

module tb_writeback_arbiter;
   import writeback_arbiter_pkg::*;

   logic                   clk;
   logic                   resetn;
   logic                   alu_valid;
   logic                   alu_ready;
   logic [4:0]             alu_rd;
   logic [31:0]            alu_data;
   logic                   mem_valid;
   logic                   mem_ready;
   logic [4:0]             mem_rd;
   logic [31:0]            mem_data;
   rv32_writeback_packet_t writeback_packet;
   logic [2:0]             fifo_count;

   int nchk = 0;
   int nerr = 0;
   rv32_writeback_packet_t wq[$];

   writeback_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .alu_valid        (alu_valid),
      .alu_ready        (alu_ready),
      .alu_rd           (alu_rd),
      .alu_data         (alu_data),
      .mem_valid        (mem_valid),
      .mem_ready        (mem_ready),
      .mem_rd           (mem_rd),
      .mem_data         (mem_data),
      .writeback_packet (writeback_packet),
      .fifo_count       (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge, settle, and log any register write.
   task automatic tick();
      @(posedge clk);
      #1;
      if (writeback_packet.wb_en) wq.push_back(writeback_packet);
   endtask

   initial begin
      int m;
      int a;
      logic mf;
      logic af;
      int alu_seq[$];
      int exp4[9];

      resetn    = 1'b0;
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_data  = '0;
      mem_valid = 1'b0;
      mem_rd    = '0;
      mem_data  = '0;
      exp4      = '{20, 21, 1, 2, 3, 4, 5, 6, 7};

      #12;
      check("rst_wb_en", 32'(writeback_packet.wb_en), 32'd0);
      check("rst_wb_sel", 32'(writeback_packet.wb_sel), 32'd0);
      check("rst_wb_data", writeback_packet.wb_data, 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_alu_ready", 32'(alu_ready), 32'd1);
      resetn = 1'b1;
      tick();

      // Single ALU write: 2-edge latency.
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      check("t1_alu_ready", 32'(alu_ready), 32'd1);
      tick();
      alu_valid = 1'b0;
      check("t1_n_wb_en", 32'(writeback_packet.wb_en), 32'd0);
      check("t1_n_count", 32'(fifo_count), 32'd1);
      tick();
      check("t1_wb_en", 32'(writeback_packet.wb_en), 32'd1);
      check("t1_wb_sel", 32'(writeback_packet.wb_sel), 32'd5);
      check("t1_wb_data", writeback_packet.wb_data, 32'hDEADBEEF);
      check("t1_count", 32'(fifo_count), 32'd0);
      tick();
      check("t1_wb_en_off", 32'(writeback_packet.wb_en), 32'd0);

      // x0 suppression on both channels.
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234;
      #1;
      check("t2_mem_ready", 32'(mem_ready), 32'd1);
      tick();
      mem_valid = 1'b0;
      check("t2_mem_wb_en", 32'(writeback_packet.wb_en), 32'd0);
      check("t2_mem_wb_data", writeback_packet.wb_data, 32'h1234);
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5678;
      tick();
      alu_valid = 1'b0;
      tick();
      check("t2_alu_wb_en", 32'(writeback_packet.wb_en), 32'd0);
      check("t2_alu_wb_data", writeback_packet.wb_data, 32'h5678);
      check("t2_alu_count", 32'(fifo_count), 32'd0);
      tick();

      // Fill/backpressure with continuous memory traffic and the starvation guard.
      wq.delete();
      m = 1;
      a = 10;
      for (int c = 0; c <= 20; c++) begin
         mem_valid = 1'b1;
         mem_rd    = 5'(m);
         mem_data  = 32'hB000_0000 | 32'(m);
         alu_valid = (a <= 14);
         alu_rd    = 5'(a);
         alu_data  = 32'hA000_0000 | 32'(a);
         #1;
         check($sformatf("t3_mem_ready_c%0d", c), 32'(mem_ready),
               ((c % 4 == 0) && (c > 0)) ? 32'd0 : 32'd1);
         if (c == 4) check("t3_alu_ready_full", 32'(alu_ready), 32'd0);
         if (c == 5) check("t3_alu_ready_free", 32'(alu_ready), 32'd1);
         mf = mem_valid && mem_ready;
         af = alu_valid && alu_ready;
         tick();
         if (c == 4) begin
            check("t3_forced_sel", 32'(writeback_packet.wb_sel), 32'd10);
            check("t3_forced_data", writeback_packet.wb_data, 32'hA000_000A);
         end
         if (mf) m++;
         if (af) a++;
      end
      mem_valid = 1'b0;
      alu_valid = 1'b0;
      tick();
      tick();
      check("t3_count", 32'(fifo_count), 32'd0);
      check("t3_total_writes", 32'(wq.size()), 32'd21);
      foreach (wq[i]) if (wq[i].wb_data[31:28] == 4'hA) alu_seq.push_back(int'(wq[i].wb_sel));
      check("t3_alu_writes", 32'(alu_seq.size()), 32'd5);
      for (int i = 0; i < 5 && i < alu_seq.size(); i++)
         check($sformatf("t3_alu_order_%0d", i), 32'(alu_seq[i]), 32'(10 + i));

      // Simultaneous push and pop at count 2.
      wq.delete();
      for (int c = 0; c < 7; c++) begin
         mem_valid = (c < 2);
         mem_rd    = 5'(20 + c);
         mem_data  = 32'hB000_0000 | 32'(20 + c);
         alu_valid = 1'b1;
         alu_rd    = 5'(c + 1);
         alu_data  = 32'hA000_0000 | 32'(c + 1);
         tick();
         if (c >= 1) check($sformatf("t4_count_c%0d", c), 32'(fifo_count), 32'd2);
      end
      mem_valid = 1'b0;
      alu_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("t4_count_end", 32'(fifo_count), 32'd0);
      check("t4_writes", 32'(wq.size()), 32'd9);
      for (int i = 0; i < 9 && i < wq.size(); i++)
         check($sformatf("t4_seq_%0d", i), 32'(wq[i].wb_sel), 32'(exp4[i]));

      // Pointer wrap-around: nine results through a depth-4 FIFO.
      wq.delete();
      for (int i = 1; i <= 9; i++) begin
         alu_valid = 1'b1;
         alu_rd    = 5'(i);
         alu_data  = 32'hC0DE_0000 + 32'(i);
         tick();
      end
      alu_valid = 1'b0;
      tick();
      tick();
      check("t5_writes", 32'(wq.size()), 32'd9);
      for (int i = 0; i < 9 && i < wq.size(); i++)
         check($sformatf("t5_data_%0d", i), wq[i].wb_data, 32'hC0DE_0000 + 32'(i + 1));

      // Reset mid-operation with three buffered entries.
      for (int i = 0; i < 3; i++) begin
         mem_valid = 1'b1;
         mem_rd    = 5'd30;
         mem_data  = 32'hB000_0030 + 32'(i);
         alu_valid = 1'b1;
         alu_rd    = 5'(16 + i);
         alu_data  = 32'hA000_0010 + 32'(i);
         tick();
      end
      mem_valid = 1'b0;
      alu_valid = 1'b0;
      check("t6_pre_wb_en", 32'(writeback_packet.wb_en), 32'd1);
      check("t6_pre_count", 32'(fifo_count), 32'd3);
      resetn = 1'b0;
      #1;
      check("t6_async_wb_en", 32'(writeback_packet.wb_en), 32'd0);
      check("t6_async_count", 32'(fifo_count), 32'd0);
      @(posedge clk);
      #2;
      resetn = 1'b1;
      wq.delete();
      for (int i = 0; i < 5; i++) tick();
      check("t6_no_stale", 32'(wq.size()), 32'd0);
      check("t6_count", 32'(fifo_count), 32'd0);
      check("t6_alu_ready", 32'(alu_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
